// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - framebuffer read port between scan-out and framebuffer memory
interface fb_scanout_if #(
   parameter int FB_ADDRW = 15,
   parameter int FB_DATAW = 4
);
   logic [FB_ADDRW-1:0] fb_addr_read;
   logic                fb_re;
   logic [FB_DATAW-1:0] fb_data;

   modport master (output fb_addr_read, output fb_re, input fb_data);
   modport slave  (input fb_addr_read, input fb_re, output fb_data);
endinterface

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - framebuffer scan-out: upscaled address generation and pixel alignment pipeline
// Optional border overlay enabled by defining FB_SCANOUT_BORDER_EN.
module fb_scanout #(
   parameter int CORDW      = 16,
   parameter int FB_WIDTH   = 160,
   parameter int FB_HEIGHT  = 120,
   parameter int FB_ADDRW   = $clog2(FB_WIDTH*FB_HEIGHT),
   parameter int FB_DATAW   = 4,
   parameter int SCALE      = 4,
   parameter int OFFSET_X   = 0,
   parameter int OFFSET_Y   = 0,
   parameter int READ_LAT   = 1,
   parameter int BORDER_IDX = 15
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   input  logic signed [CORDW-1:0] sx,
   input  logic signed [CORDW-1:0] sy,
   input  logic                    de,
   input  logic                    frame,
   fb_scanout_if.master            fb,
   output logic [FB_DATAW-1:0]     pix_idx,
   output logic                    pix_in_fb,
   output logic signed [CORDW-1:0] pix_sx,
   output logic signed [CORDW-1:0] pix_sy,
   output logic                    pix_de,
   output logic                    frame_done
);
   localparam int NSTG = READ_LAT + 2;
   localparam int COLW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
   localparam int SUBW = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic signed [CORDW-1:0] X_LO = CORDW'(OFFSET_X);
   localparam logic signed [CORDW-1:0] X_HI = CORDW'(OFFSET_X + FB_WIDTH*SCALE);
   localparam logic signed [CORDW-1:0] Y_LO = CORDW'(OFFSET_Y);
   localparam logic signed [CORDW-1:0] Y_HI = CORDW'(OFFSET_Y + FB_HEIGHT*SCALE);

   localparam logic [COLW-1:0]     COL_MAX   = COLW'(FB_WIDTH-1);
   localparam logic [SUBW-1:0]     SUB_MAX   = SUBW'(SCALE-1);
   localparam logic [FB_ADDRW-1:0] ROW_STEP  = FB_ADDRW'(FB_WIDTH);
   localparam logic [FB_ADDRW-1:0] LAST_BASE = FB_ADDRW'((FB_HEIGHT-1)*FB_WIDTH);

   if (!(SCALE == 1 || SCALE == 2 || SCALE == 4 || SCALE == 8) || READ_LAT < 1 || READ_LAT > 3 ||
       BORDER_IDX < 0 || BORDER_IDX >= (1 << FB_DATAW)) begin : g_param_check
      $error("fb_scanout: illegal parameter set");
   end

   typedef enum logic [1:0] {WAIT_FRAME, SCAN, DONE} state_t;

   state_t              state;
   logic [FB_ADDRW-1:0] row_base;
   logic [COLW-1:0]     col;
   logic [SUBW-1:0]     sub_x;
   logic [SUBW-1:0]     line_rep;
   logic                first_line;
   logic [FB_ADDRW-1:0] addr_q;
   logic                re_q;
   logic                done_q;

   logic                in_area;
   logic                rd;
   logic                last_rd;
   logic [FB_ADDRW-1:0] row_n;
   logic [COLW-1:0]     col_n;
   logic [SUBW-1:0]     sub_n;
   logic [SUBW-1:0]     rep_n;
   logic                first_n;
   logic [FB_ADDRW-1:0] addr_n;

   // A line is recognised by its first image column; the first line after a
   // frame pulse keeps row 0, every later one steps the line-repeat counter.
   always_comb begin
      in_area = !sx[CORDW-1] && !sy[CORDW-1] &&
                (sx >= X_LO) && (sx < X_HI) && (sy >= Y_LO) && (sy < Y_HI);
      rd      = in_area && (frame || state == SCAN);
      row_n   = frame ? '0 : row_base;
      col_n   = frame ? '0 : col;
      sub_n   = frame ? '0 : sub_x;
      rep_n   = frame ? '0 : line_rep;
      first_n = frame ? 1'b1 : first_line;
      addr_n  = addr_q;
      last_rd = 1'b0;
      if (rd) begin
         if (sx == X_LO) begin
            col_n = '0;
            sub_n = '0;
            if (!first_n) begin
               if (rep_n == SUB_MAX) begin
                  rep_n = '0;
                  if (row_n != LAST_BASE) begin
                     row_n = row_n + ROW_STEP;
                  end
               end else begin
                  rep_n = rep_n + 1'b1;
               end
            end
            first_n = 1'b0;
         end
         addr_n  = row_n + FB_ADDRW'(col_n);
         last_rd = (row_n == LAST_BASE) && (rep_n == SUB_MAX) &&
                   (col_n == COL_MAX) && (sub_n == SUB_MAX);
         if (sub_n == SUB_MAX) begin
            sub_n = '0;
            if (col_n != COL_MAX) begin
               col_n = col_n + 1'b1;
            end
         end else begin
            sub_n = sub_n + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state      <= WAIT_FRAME;
         row_base   <= '0;
         col        <= '0;
         sub_x      <= '0;
         line_rep   <= '0;
         first_line <= 1'b0;
         addr_q     <= '0;
         re_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         row_base   <= row_n;
         col        <= col_n;
         sub_x      <= sub_n;
         line_rep   <= rep_n;
         first_line <= first_n;
         addr_q     <= addr_n;
         re_q       <= rd;
         done_q     <= 1'b0;
         if (frame) begin
            state <= SCAN;
         end else begin
            case (state)
               SCAN: begin
                  if (last_rd) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
               WAIT_FRAME: state <= WAIT_FRAME;
               DONE:       state <= DONE;
               default:    state <= WAIT_FRAME;
            endcase
         end
      end
   end

   assign fb.fb_addr_read = addr_q;
   assign fb.fb_re        = re_q;
   assign frame_done      = done_q;

   logic [NSTG-1:0][CORDW-1:0] sx_d;
   logic [NSTG-1:0][CORDW-1:0] sy_d;
   logic [NSTG-1:0]            de_d;
   logic [NSTG-1:0]            in_d;

`ifdef FB_SCANOUT_BORDER_EN
   localparam logic signed [CORDW-1:0] X_BL = CORDW'(OFFSET_X + SCALE);
   localparam logic signed [CORDW-1:0] X_BR = CORDW'(OFFSET_X + (FB_WIDTH-1)*SCALE);
   localparam logic signed [CORDW-1:0] Y_BT = CORDW'(OFFSET_Y + SCALE);
   localparam logic signed [CORDW-1:0] Y_BB = CORDW'(OFFSET_Y + (FB_HEIGHT-1)*SCALE);

   logic [NSTG-1:0] bd_d;
   logic            border;

   assign border = rd && ((sx < X_BL) || (sx >= X_BR) || (sy < Y_BT) || (sy >= Y_BB));
`endif

   // Sideband travels NSTG stages; fb_data is sampled one stage early so it
   // lands in pix_idx together with the sideband of the pixel that requested it.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         sx_d    <= '0;
         sy_d    <= '0;
         de_d    <= '0;
         in_d    <= '0;
         pix_idx <= '0;
`ifdef FB_SCANOUT_BORDER_EN
         bd_d    <= '0;
`endif
      end else begin
         sx_d <= {sx_d[NSTG-2:0], sx};
         sy_d <= {sy_d[NSTG-2:0], sy};
         de_d <= {de_d[NSTG-2:0], de};
         in_d <= {in_d[NSTG-2:0], rd};
`ifdef FB_SCANOUT_BORDER_EN
         bd_d <= {bd_d[NSTG-2:0], border};
         if (!in_d[NSTG-2]) begin
            pix_idx <= '0;
         end else if (bd_d[NSTG-2]) begin
            pix_idx <= FB_DATAW'(BORDER_IDX);
         end else begin
            pix_idx <= fb.fb_data;
         end
`else
         pix_idx <= in_d[NSTG-2] ? fb.fb_data : '0;
`endif
      end
   end

   assign pix_sx    = $signed(sx_d[NSTG-1]);
   assign pix_sy    = $signed(sy_d[NSTG-1]);
   assign pix_de    = de_d[NSTG-1];
   assign pix_in_fb = in_d[NSTG-1];
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - bench for fb_scanout: default instance and READ_LAT=2 instance on shared stimulus
module tb_fb_scanout;
   localparam int W = 160;
   localparam int H = 120;
   localparam int S = 4;
   localparam int OX = 0;
   localparam int OY = 0;

   logic clk_pix = 1'b0;
   logic rst_pix_n = 1'b0;
   logic signed [15:0] sx_i = '0;
   logic signed [15:0] sy_i = '0;
   logic de_i = 1'b0;
   logic frame_i = 1'b0;

   fb_scanout_if #(.FB_ADDRW(15), .FB_DATAW(4)) fb0 ();
   fb_scanout_if #(.FB_ADDRW(15), .FB_DATAW(4)) fb1 ();

   logic [3:0] pidx0, pidx1;
   logic pin0, pin1, pde0, pde1, done0, done1;
   logic signed [15:0] psx0, psy0, psx1, psy1;
   logic [3:0] mem0, mem1_a, mem1;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   fb_scanout u_def (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx_i), .sy(sy_i), .de(de_i), .frame(frame_i),
      .fb(fb0), .pix_idx(pidx0), .pix_in_fb(pin0), .pix_sx(psx0), .pix_sy(psy0),
      .pix_de(pde0), .frame_done(done0)
   );

   fb_scanout #(.READ_LAT(2)) u_lat (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx_i), .sy(sy_i), .de(de_i), .frame(frame_i),
      .fb(fb1), .pix_idx(pidx1), .pix_in_fb(pin1), .pix_sx(psx1), .pix_sy(psy1),
      .pix_de(pde1), .frame_done(done1)
   );

   always #5 clk_pix = ~clk_pix;

   // Framebuffer contents are addr[3:0]; latency 1 and 2 respectively.
   always @(posedge clk_pix) mem0 <= fb0.fb_addr_read[3:0];
   always @(posedge clk_pix) begin
      mem1_a <= fb1.fb_addr_read[3:0];
      mem1   <= mem1_a;
   end
   assign fb0.fb_data = mem0;
   assign fb1.fb_data = mem1;

   typedef struct {
      bit       in_fb;
      bit [3:0] idx;
      int       sx;
      int       sy;
      bit       de;
   } pix_t;

   pix_t q[$];
   int   cx, cy;
   int   m_addr;
   bit   m_re, m_done, m_active;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      pix_t z;
      z = '{in_fb: 1'b0, idx: 4'd0, sx: 0, sy: 0, de: 1'b0};
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(z);
      m_addr = 0;
      m_re = 1'b0;
      m_done = 1'b0;
      m_active = 1'b0;
   endtask

   // Expected behaviour from screen coordinates: address by division, scan
   // active from a frame pulse until the bottom-right image pixel is read.
   task automatic m_update();
      bit ia, rd, last;
      pix_t e;
      ia = cx >= OX && cx < OX + W*S && cy >= OY && cy < OY + H*S;
      if (frame_i) m_active = 1'b1;
      rd = ia && m_active;
      last = 1'b0;
      if (rd) begin
         m_addr = ((cy - OY) / S) * W + (cx - OX) / S;
         last = (m_addr == W*H - 1) && (cy == OY + H*S - 1) && (cx == OX + W*S - 1);
      end
      m_re = rd;
      m_done = last && !frame_i;
      if (last) m_active = 1'b0;
      e.in_fb = rd;
      e.idx = rd ? m_addr[3:0] : 4'd0;
`ifdef FB_SCANOUT_BORDER_EN
      if (rd && ((cx - OX) < S || (cx - OX) >= (W-1)*S || (cy - OY) < S || (cy - OY) >= (H-1)*S))
         e.idx = 4'd15;
`endif
      e.sx = cx;
      e.sy = cy;
      e.de = de_i;
      q.push_back(e);
      void'(q.pop_front());
   endtask

   always @(negedge clk_pix) begin
      if (run) begin
         chk("def_addr", int'(fb0.fb_addr_read), m_addr);
         chk("def_re", int'(fb0.fb_re), int'(m_re));
         chk("def_done", int'(done0), int'(m_done));
         chk("def_idx", int'(pidx0), int'(q[1].idx));
         chk("def_in_fb", int'(pin0), int'(q[1].in_fb));
         chk("def_pix_sx", int'(psx0), q[1].sx);
         chk("def_pix_sy", int'(psy0), q[1].sy);
         chk("def_pix_de", int'(pde0), int'(q[1].de));
         chk("lat_addr", int'(fb1.fb_addr_read), m_addr);
         chk("lat_re", int'(fb1.fb_re), int'(m_re));
         chk("lat_done", int'(done1), int'(m_done));
         chk("lat_idx", int'(pidx1), int'(q[0].idx));
         chk("lat_in_fb", int'(pin1), int'(q[0].in_fb));
         chk("lat_pix_sx", int'(psx1), q[0].sx);
         chk("lat_pix_sy", int'(psy1), q[0].sy);
         chk("lat_pix_de", int'(pde1), int'(q[0].de));
      end
   end

   task automatic step(input int x, input int y, input bit f);
      sx_i = 16'(x);
      sy_i = 16'(y);
      frame_i = f;
      de_i = (x >= 0 && x < 640 && y >= 0 && y < 480);
      cx = x;
      cy = y;
      @(posedge clk_pix);
      m_update();
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_def_addr"}, int'(fb0.fb_addr_read), 0);
      chk({tag, "_def_re"}, int'(fb0.fb_re), 0);
      chk({tag, "_def_idx"}, int'(pidx0), 0);
      chk({tag, "_def_in_fb"}, int'(pin0), 0);
      chk({tag, "_def_sx"}, int'(psx0), 0);
      chk({tag, "_def_sy"}, int'(psy0), 0);
      chk({tag, "_def_de"}, int'(pde0), 0);
      chk({tag, "_def_done"}, int'(done0), 0);
      chk({tag, "_lat_addr"}, int'(fb1.fb_addr_read), 0);
      chk({tag, "_lat_in_fb"}, int'(pin1), 0);
      chk({tag, "_lat_sx"}, int'(psx1), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      m_reset();
      repeat (2) @(posedge clk_pix);
      #1;
      run = 1'b1;
      chk_zero("por");
      rst_pix_n = 1'b1;

      // in-area before any frame pulse must not read
      step(0, 0, 1'b0);
      chk("noframe_re", int'(fb0.fb_re), 0);
      step(1, 0, 1'b0);

      step(-5, -1, 1'b1);
      for (int x = 0; x < 640; x++) begin
         step(x, 0, 1'b0);
         if (x < 4) begin
            chk("l0_first_addr", int'(fb0.fb_addr_read), 0);
            chk("l0_first_re", int'(fb0.fb_re), 1);
         end
         if (x == 4) chk("l0_x4_addr", int'(fb0.fb_addr_read), 1);
         if (x == 10) begin
            chk("def_x8_idx", int'(pidx0), 2);
            chk("def_x8_sx", int'(psx0), 8);
         end
         if (x == 11) begin
            chk("lat_x8_idx", int'(pidx1), 2);
            chk("lat_x8_in_fb", int'(pin1), 1);
            chk("lat_x8_sx", int'(psx1), 8);
         end
      end
      step(640, 0, 1'b0);
      chk("x640_re", int'(fb0.fb_re), 0);
      step(-16, 0, 1'b0);
      chk("xneg_re", int'(fb0.fb_re), 0);
      step(-16, 0, 1'b0);
      chk("x640_in_fb", int'(pin0), 0);
      chk("x640_idx", int'(pidx0), 0);

      for (int y = 1; y < 7; y++) begin
         step(0, y, 1'b0);
         if (y == 4) chk("y4_addr", int'(fb0.fb_addr_read), 160);
      end
      for (int x = 0; x < 640; x++) begin
         step(x, 7, 1'b0);
         if (x == 639) chk("y7_x639_addr", int'(fb0.fb_addr_read), 319);
      end
      for (int y = 8; y < 479; y++) step(0, y, 1'b0);
      for (int x = 0; x < 640; x++) begin
         step(x, 479, 1'b0);
         if (x == 639) begin
            chk("last_addr", int'(fb0.fb_addr_read), 19199);
            chk("last_done", int'(done0), 1);
         end
      end
      step(-16, 479, 1'b0);
      chk("done_one_cycle", int'(done0), 0);
      step(0, 0, 1'b0);
      chk("done_state_re", int'(fb0.fb_re), 0);
      step(10, 480, 1'b0);
      chk("y480_re", int'(fb0.fb_re), 0);
      step(-16, 0, 1'b0);
      chk("done_state_in_fb", int'(pin0), 0);

      // restart coincident with first pixel, then abort mid-scan
      step(0, 0, 1'b1);
      chk("coinc_addr", int'(fb0.fb_addr_read), 0);
      chk("coinc_re", int'(fb0.fb_re), 1);
      for (int y = 1; y < 124; y++) step(0, y, 1'b0);
      for (int x = 0; x <= 160; x++) begin
         step(x, 124, 1'b0);
         if (x == 160) chk("mid_addr", int'(fb0.fb_addr_read), 5000);
      end
      step(700, 124, 1'b1);
      chk("abort_done", int'(done0), 0);
      step(0, 0, 1'b0);
      chk("abort_addr", int'(fb0.fb_addr_read), 0);
      chk("abort_re", int'(fb0.fb_re), 1);
      for (int x = 1; x < 6; x++) step(x, 0, 1'b0);

      // asynchronous reset mid-scan
      rst_pix_n = 1'b0;
      m_reset();
      #1;
      chk_zero("midrst");
      @(posedge clk_pix);
      @(posedge clk_pix);
      #1;
      rst_pix_n = 1'b1;
      step(0, 0, 1'b0);
      chk("postrst_re", int'(fb0.fb_re), 0);
      step(-1, -1, 1'b1);
      step(0, 0, 1'b0);
      chk("postrst_frame_re", int'(fb0.fb_re), 1);
      chk("postrst_frame_addr", int'(fb0.fb_addr_read), 0);

`ifdef FB_SCANOUT_BORDER_EN
      step(-1, -1, 1'b1);
      for (int y = 0; y < 100; y++) step(0, y, 1'b0);
      for (int x = 0; x < 3; x++) step(x, 100, 1'b0);
      step(-16, 100, 1'b0);
      step(-16, 100, 1'b0);
      chk("border_idx", int'(pidx0), 15);
      chk("border_in_fb", int'(pin0), 1);
      step(-1, -1, 1'b1);
      for (int y = 0; y < 4; y++) step(0, y, 1'b0);
      for (int x = 0; x < 5; x++) step(x, 4, 1'b0);
      step(-16, 4, 1'b0);
      step(-16, 4, 1'b0);
      chk("inner_idx", int'(pidx0), 1);
      chk("inner_in_fb", int'(pin0), 1);
`endif

      step(-16, -16, 1'b0);
      step(-16, -16, 1'b0);
      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CORDW, 16, signed screen coordinate width; FB_WIDTH, 160, framebuffer columns; FB_HEIGHT, 120, framebuffer rows; FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), read address width; FB_DATAW, 4, palette index bits; SCALE, 4, integer upscale factor in {1,2,4,8}; OFFSET_X, 0, first screen column of the image; OFFSET_Y, 0, first screen row of the image; READ_LAT, 1, framebuffer read latency in cycles (1..3); BORDER_IDX, 15, border palette index.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk_pix, in, 1, pixel clock, the only clock; rst_pix_n, in, 1, asynchronous active-low reset; sx, in, CORDW signed, display column; sy, in, CORDW signed, display row; de, in, 1, data enable; frame, in, 1, start-of-frame pulse; fb_addr_read, out, FB_ADDRW, framebuffer read address; fb_re, out, 1, read enable; fb_data, in, FB_DATAW, framebuffer read data; pix_idx, out, FB_DATAW, palette index; pix_in_fb, out, 1, pix_idx is image data; pix_sx, out, CORDW, delayed sx; pix_sy, out, CORDW, delayed sy; pix_de, out, 1, delayed de; frame_done, out, 1, one-cycle pulse after the last image read of a frame.

Function
REQ-003 Image area SHALL be OFFSET_X <= sx < OFFSET_X+FB_WIDTH*SCALE and OFFSET_Y <= sy < OFFSET_Y+FB_HEIGHT*SCALE, compared signed; negative coordinates are never in area.
REQ-004 For an in-area input cycle, fb_addr_read SHALL equal ((sy-OFFSET_Y)/SCALE)*FB_WIDTH + (sx-OFFSET_X)/SCALE, registered, with fb_re=1 in the same cycle.
REQ-005 Address generation SHALL use a column counter with sub-pixel counter (0..SCALE-1), a row base, and a line-repeat counter (0..SCALE-1); no multiplier or divider.
REQ-006 Row base SHALL advance by FB_WIDTH only after the line-repeat counter wraps from SCALE-1, so each framebuffer row is read on SCALE consecutive display lines.
REQ-007 fb_re SHALL be 0 and fb_addr_read hold its value on all out-of-area cycles.
REQ-008 pix_sx, pix_sy, pix_de and pix_in_fb SHALL be the inputs (pix_in_fb = in-area) delayed exactly READ_LAT+2 cycles; pix_idx SHALL be fb_data captured to align with them, and 0 when pix_in_fb=0.
REQ-009 FSM states SHALL be WAIT_FRAME, SCAN and DONE; reads occur only in SCAN.
REQ-010 WAIT_FRAME -> SCAN on frame=1; SCAN -> DONE on the cycle after the read of address FB_WIDTH*FB_HEIGHT-1 on the last repeated line, asserting frame_done for one cycle; DONE -> SCAN on frame=1.
REQ-011 frame=1 in any state (including mid-SCAN) SHALL zero all counters and row base and enter SCAN the next cycle; frame_done is not asserted for an aborted frame.
REQ-012 frame=1 coincident with an in-area input SHALL restart first, and that cycle SHALL read address 0.
REQ-013 Address arithmetic SHALL not wrap past FB_WIDTH*FB_HEIGHT-1; in-area inputs in DONE SHALL produce fb_re=0 and pix_in_fb=0.

Reset
REQ-014 While rst_pix_n=0, the FSM SHALL be WAIT_FRAME and all outputs, counters and delay stages 0, asynchronously.
REQ-015 Deassertion SHALL be taken synchronously; the first read requires a frame pulse after reset release.

Configuration
REQ-016 Macro FB_SCANOUT_BORDER_EN SHALL control the border feature.
REQ-017 With FB_SCANOUT_BORDER_EN defined, aligned output pixels in the outermost SCALE screen columns or rows of the image area SHALL output pix_idx=BORDER_IDX, pix_in_fb=1, with fb_re still asserted for address continuity.
REQ-018 Without FB_SCANOUT_BORDER_EN, no border logic SHALL be present and all in-area pixels output fb_data.

Verification
REQ-019 Defaults, frame pulse, then sx=0..3 and sy=0 -> fb_addr_read=0 with fb_re=1 on all four; sx=4 -> address 1.
REQ-020 Defaults, sy=4 and sx=0 -> address 160; sy=7 and sx=639 -> address 319; sy=479 and sx=639 -> address 19199, then frame_done pulses once.
REQ-021 READ_LAT=2 with a model returning fb_data=addr[3:0], sx=8 and sy=0 input at cycle t -> pix_idx=2, pix_in_fb=1, pix_sx=8 at cycle t+4.
REQ-022 sx=-16 or sx=640 or sy=480 -> fb_re=0, and pix_in_fb=0, pix_idx=0 after the delay.
REQ-023 frame pulse issued mid-scan at address 5000 -> next in-area read is address 0 and no frame_done occurs; rst_pix_n low mid-scan -> all outputs 0 immediately, and reads resume only after the next frame pulse.
REQ-024 FB_SCANOUT_BORDER_EN defined, sx=2 and sy=100 -> pix_idx=15; sx=4 and sy=4 -> pix_idx=fb_data.
